// File: rtl/accum_writeback.sv
// Accumulator drain: reads result rows, requantizes each lane (shift, ReLU, saturate) and writes them to the unified buffer.
// Optional macro WB_ROUND_EN adds round-half-up before the shift; default build truncates (floor).

module accum_writeback_lane #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 16
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [4:0]       shift,
   input  logic             relu_en,
   output logic [OUT_W-1:0] q
);
   localparam logic signed [ACC_W:0] MAXV = $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [ACC_W:0] MINV = $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

   logic signed [ACC_W:0] ext, y, yr;

`ifdef WB_ROUND_EN
   logic signed [ACC_W:0] rnd;
   // One extra bit of headroom keeps the rounding add from overflowing.
   assign rnd = (shift == 5'd0) ? '0 : $signed({{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1));
   assign ext = $signed({acc[ACC_W-1], acc}) + rnd;
`else
   assign ext = $signed({acc[ACC_W-1], acc});
`endif

   assign y  = ext >>> shift;
   assign yr = (relu_en && y[ACC_W]) ? '0 : y;

   always_comb begin
      q = yr[OUT_W-1:0];
      if (yr > MAXV)      q = MAXV[OUT_W-1:0];
      else if (yr < MINV) q = MINV[OUT_W-1:0];
   end
endmodule

module accum_writeback #(
   parameter int LANES  = 32,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 16,
   parameter int ACC_AW = 7,
   parameter int UB_AW  = 12
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [ACC_AW-1:0]            acc_base_addr_i,
   input  logic [UB_AW-1:0]             ub_base_addr_i,
   input  logic [7:0]                   num_rows_i,
   input  logic [4:0]                   shift_i,
   input  logic                         relu_en_i,
   output logic                         acc_rd_en_o,
   output logic [ACC_AW-1:0]            acc_addr_rd_o,
   input  logic [LANES-1:0][ACC_W-1:0]  acc_data_i,
   output logic                         ub_write_o,
   output logic [UB_AW-1:0]             ub_addr_wr_o,
   output logic [LANES-1:0][OUT_W-1:0]  ub_data_o,
   input  logic                         ub_ready_i,
   output logic                         busy_o,
   output logic                         done_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [ACC_AW-1:0] acc_base;
      logic [UB_AW-1:0]  ub_base;
      logic [7:0]        num_rows;
      logic [4:0]        shift;
      logic              relu;
   } cfg_t;

   state_t state, state_nxt;
   cfg_t   cfg_q;

   logic [7:0] rows_issued, rows_written;
   logic [1:0] occ;
   logic [2:0] occ_left;
   logic       accept, last_wr, rd_vld;

   logic [LANES-1:0][ACC_W-1:0] skid [2];
   logic [LANES-1:0][ACC_W-1:0] head;
   logic [LANES-1:0][OUT_W-1:0] req;
   logic       wr_ptr, rd_ptr, out_vld;
   logic [1:0] skid_cnt, skid_cnt_nxt;
   logic       out_ld, push, pop;

   assign accept   = out_vld & ub_ready_i;
   assign last_wr  = (rows_written == cfg_q.num_rows - 8'd1);
   // occ covers in-flight reads, skid entries and the output stage: at most 3 rows.
   assign occ_left = {1'b0, occ} - {2'b0, accept};

   assign acc_rd_en_o   = (state == RUN) && (rows_issued < cfg_q.num_rows) && (occ_left < 3'd3);
   assign acc_addr_rd_o = cfg_q.acc_base + ACC_AW'(rows_issued);
   assign ub_addr_wr_o  = cfg_q.ub_base + UB_AW'(rows_written);
   assign ub_write_o    = out_vld;
   assign busy_o        = (state == RUN);
   assign done_o        = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = (num_rows_i == 8'd0) ? DONE : RUN;
         RUN:     if (accept && last_wr) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         cfg_q        <= '0;
         rows_issued  <= '0;
         rows_written <= '0;
         occ          <= '0;
      end else begin
         state <= state_nxt;
         occ   <= occ + {1'b0, acc_rd_en_o} - {1'b0, accept};
         if (state == IDLE && start_i) begin
            cfg_q        <= '{acc_base: acc_base_addr_i, ub_base: ub_base_addr_i,
                              num_rows: num_rows_i, shift: shift_i, relu: relu_en_i};
            rows_issued  <= '0;
            rows_written <= '0;
         end else begin
            if (acc_rd_en_o) rows_issued  <= rows_issued + 8'd1;
            if (accept)      rows_written <= rows_written + 8'd1;
         end
      end
   end

   // An empty skid lets the arriving row bypass straight into the output stage.
   assign head         = (skid_cnt != 2'd0) ? skid[rd_ptr] : acc_data_i;
   assign out_ld       = (!out_vld || accept) && ((skid_cnt != 2'd0) || rd_vld);
   assign pop          = out_ld && (skid_cnt != 2'd0);
   assign push         = rd_vld && !(out_ld && (skid_cnt == 2'd0));
   assign skid_cnt_nxt = skid_cnt + {1'b0, push} - {1'b0, pop};

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      accum_writeback_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
         .acc     (head[l]),
         .shift   (cfg_q.shift),
         .relu_en (cfg_q.relu),
         .q       (req[l])
      );
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_vld    <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         skid_cnt  <= '0;
         out_vld   <= 1'b0;
         ub_data_o <= '0;
         for (int i = 0; i < 2; i++) skid[i] <= '0;
      end else begin
         rd_vld   <= acc_rd_en_o;
         skid_cnt <= skid_cnt_nxt;
         if (push) begin
            skid[wr_ptr] <= acc_data_i;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (out_ld) begin
            out_vld   <= 1'b1;
            ub_data_o <= req;
         end else if (accept) begin
            out_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_accum_writeback.sv
// Self-checking bench for accum_writeback: scripted and random tiles against a row-level reference model.
module tb_accum_writeback;
   localparam int LANES = 32, ACC_W = 32, OUT_W = 16, ACC_AW = 7, UB_AW = 12;
   localparam int RW = LANES * OUT_W;

   typedef logic [LANES-1:0][ACC_W-1:0] arow_t;
   typedef logic [LANES-1:0][OUT_W-1:0] orow_t;

   logic              clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
   logic [ACC_AW-1:0] acc_base_addr_i = '0;
   logic [UB_AW-1:0]  ub_base_addr_i = '0;
   logic [7:0]        num_rows_i = '0;
   logic [4:0]        shift_i = '0;
   logic              relu_en_i = 1'b0, ub_ready_i = 1'b1;
   arow_t             acc_data_i = '0;
   logic              acc_rd_en_o, ub_write_o, busy_o, done_o;
   logic [ACC_AW-1:0] acc_addr_rd_o;
   logic [UB_AW-1:0]  ub_addr_wr_o;
   orow_t             ub_data_o;

   accum_writeback dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .acc_base_addr_i(acc_base_addr_i), .ub_base_addr_i(ub_base_addr_i),
      .num_rows_i(num_rows_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
      .acc_rd_en_o(acc_rd_en_o), .acc_addr_rd_o(acc_addr_rd_o), .acc_data_i(acc_data_i),
      .ub_write_o(ub_write_o), .ub_addr_wr_o(ub_addr_wr_o), .ub_data_o(ub_data_o),
      .ub_ready_i(ub_ready_i), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   arow_t mem [128];

   logic [ACC_AW-1:0] exp_raddr [$];
   logic [UB_AW-1:0]  exp_waddr [$];
   orow_t             exp_data  [$];
   orow_t             wr_log    [$];
   int n_rd, n_acc, n_done, first_rd, first_wr, last_acc, done_cyc, start_cyc;
   int rdy_mode = 0, stall_left = 0;
   bit stall_prev = 0;
   logic [UB_AW-1:0] prev_addr;
   orow_t            prev_data;

   task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] ref_q(input longint v, input int sh, input bit relu);
      longint y;
`ifdef WB_ROUND_EN
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
      y = v >>> sh;
      if (relu && y < 0) y = 0;
      if (y > 32767) y = 32767;
      else if (y < -32768) y = -32768;
      return OUT_W'(y);
   endfunction

   function automatic orow_t model_row(input arow_t a, input int sh, input bit relu);
      orow_t r;
      for (int l = 0; l < LANES; l++) r[l] = ref_q(longint'($signed(a[l])), sh, relu);
      return r;
   endfunction

   always @(posedge clk_i) cyc++;

   // Accumulator memory: data appears the cycle after the read strobe, garbage otherwise.
   initial begin
      logic v;
      logic [ACC_AW-1:0] a;
      forever begin
         @(negedge clk_i);
         v = acc_rd_en_o;
         a = acc_addr_rd_o;
         @(posedge clk_i);
         #1;
         if (v) acc_data_i = mem[a];
         else for (int l = 0; l < LANES; l++) acc_data_i[l] = $urandom;
      end
   end

   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         1: ub_ready_i = ($urandom % 4) != 0;
         2: begin
            if (stall_left > 0) begin
               ub_ready_i = 1'b0;
               stall_left--;
            end else ub_ready_i = 1'b1;
         end
         default: ub_ready_i = 1'b1;
      endcase
   end

   always @(negedge clk_i) begin
      if (!rst_i) stall_prev = 0;
      else begin
         if (stall_prev) begin
            chk("stall_wr", ub_write_o, 1);
            chk("stall_addr", ub_addr_wr_o, prev_addr);
            chk("stall_data", ub_data_o, prev_data);
         end
         stall_prev = ub_write_o && !ub_ready_i;
         prev_addr  = ub_addr_wr_o;
         prev_data  = ub_data_o;
         if (ub_write_o && ub_ready_i) begin
            n_acc++;
            last_acc = cyc;
            if (first_wr < 0) first_wr = cyc;
            if (exp_data.size() > 0) begin
               chk("wr_addr", ub_addr_wr_o, exp_waddr.pop_front());
               chk("wr_data", ub_data_o, exp_data.pop_front());
            end else chk("wr_extra", 1, 0);
            wr_log.push_back(ub_data_o);
            if (rdy_mode == 2 && n_acc == 2) stall_left = 5;
         end
         if (acc_rd_en_o) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            if (exp_raddr.size() > 0) chk("rd_addr", acc_addr_rd_o, exp_raddr.pop_front());
            else chk("rd_extra", 1, 0);
            chk("occ_max", (n_rd - n_acc) <= 3, 1);
         end
         if (done_o) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic prep(input int ab, input int ub, input int rows, input int sh, input bit relu, input int mode);
      exp_raddr.delete(); exp_waddr.delete(); exp_data.delete(); wr_log.delete();
      for (int i = 0; i < rows; i++) begin
         exp_raddr.push_back(ACC_AW'(ab + i));
         exp_waddr.push_back(UB_AW'(ub + i));
         exp_data.push_back(model_row(mem[(ab + i) % 128], sh, relu));
      end
      n_rd = 0; n_acc = 0; n_done = 0;
      first_rd = -1; first_wr = -1; last_acc = -1; done_cyc = -1;
      rdy_mode = mode;
   endtask

   task automatic kick(input int ab, input int ub, input int rows, input int sh, input bit relu);
      @(posedge clk_i); #1;
      start_i = 1; acc_base_addr_i = ACC_AW'(ab); ub_base_addr_i = UB_AW'(ub);
      num_rows_i = 8'(rows); shift_i = 5'(sh); relu_en_i = relu;
      start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 0;
   endtask

   task automatic run_tile(input int ab, input int ub, input int rows, input int sh,
                           input bit relu, input int mode, input bit disturb);
      int k;
      prep(ab, ub, rows, sh, relu, mode);
      kick(ab, ub, rows, sh, relu);
      if (disturb) begin
         @(posedge clk_i); #1;
         start_i = 1; num_rows_i = 8'(rows + 3); shift_i = 5'(sh + 3); relu_en_i = !relu;
         acc_base_addr_i = ACC_AW'(ab + 40); ub_base_addr_i = UB_AW'(ub + 40);
         @(posedge clk_i); #1;
         start_i = 0;
      end
      k = 0;
      while (n_done == 0 && k < 3000) begin
         @(posedge clk_i);
         k++;
      end
      if (n_done == 0) chk("timeout", 0, 1);
      repeat (3) @(posedge clk_i);
      #1;
      chk("done_once", n_done, 1);
      chk("rows_wr", n_acc, rows);
      chk("rows_rd", n_rd, rows);
      chk("idle_busy", busy_o, 0);
   endtask

   task automatic fill_rand(input int r);
      for (int l = 0; l < LANES; l++)
         case ($urandom % 3)
            0: mem[r][l] = $urandom;
            1: mem[r][l] = ACC_W'($urandom_range(0, 2000) - 1000);
            default: mem[r][l] = ACC_W'($signed($urandom_range(0, 131071) - 65536) * 64);
         endcase
   endtask

   initial begin
      int n0, r0;
      for (int r = 0; r < 128; r++) fill_rand(r);
      #2;
      chk("rst_rd_en", acc_rd_en_o, 0);
      chk("rst_rd_addr", acc_addr_rd_o, 0);
      chk("rst_wr", ub_write_o, 0);
      chk("rst_wr_addr", ub_addr_wr_o, 0);
      chk("rst_data", ub_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1;

      // Basic drain, latency and done timing.
      for (int r = 0; r < 4; r++) mem[r][0] = ACC_W'(10 * r);
      run_tile(0, 'h100, 4, 0, 0, 0, 0);
      chk("t1_cnt", wr_log.size(), 4);
      if (wr_log.size() == 4)
         for (int r = 0; r < 4; r++) chk("t1_lane0", wr_log[r][0], 16'(10 * r));
      chk("t1_lat", first_wr - first_rd, 2);
      chk("t1_done_lat", done_cyc - last_acc, 1);

      // Saturation and shift.
      mem[10][0] = 32'h0001_0000; mem[10][1] = 32'hFFFF_0000;
      run_tile(10, 'h200, 1, 0, 0, 0, 0);
      if (wr_log.size() == 1) begin
         chk("sat_pos", wr_log[0][0], 16'h7FFF);
         chk("sat_neg", wr_log[0][1], 16'h8000);
      end else chk("t2_cnt", wr_log.size(), 1);
      run_tile(10, 'h200, 1, 8, 0, 0, 0);
      if (wr_log.size() == 1) chk("shift8", wr_log[0][0], 16'h0100);
      else chk("t2b_cnt", wr_log.size(), 1);

      // ReLU, plus a start pulse while busy that must be ignored.
      mem[20][0] = -32'sd5;
      run_tile(20, 'h300, 6, 0, 1, 0, 1);
      if (wr_log.size() == 6) chk("relu_on", wr_log[0][0], 16'h0000);
      run_tile(20, 'h300, 1, 0, 0, 0, 0);
      if (wr_log.size() == 1) chk("relu_off", wr_log[0][0], 16'hFFFB);

      // Backpressure: 5-cycle stall after the 2nd write.
      run_tile(40, 'h400, 8, 2, 0, 2, 0);
      rdy_mode = 0;

      // Address wrap on both sides.
      run_tile(126, 'hFFE, 4, 1, 0, 0, 0);

      // Zero-row tile.
      run_tile(5, 'h10, 0, 0, 0, 0, 0);
      chk("zero_lat", done_cyc - start_cyc, 1);

      // Rounding behaviour at shift 1.
      mem[30][0] = 32'sd3; mem[30][1] = -32'sd3;
      run_tile(30, 'h500, 1, 1, 0, 0, 0);
      if (wr_log.size() == 1) begin
`ifdef WB_ROUND_EN
         chk("rnd_pos", wr_log[0][0], 16'd2);
         chk("rnd_neg", wr_log[0][1], 16'hFFFF);
`else
         chk("trunc_pos", wr_log[0][0], 16'd1);
         chk("trunc_neg", wr_log[0][1], 16'hFFFE);
`endif
      end

      // Random tiles with random backpressure.
      for (int t = 0; t < 8; t++) begin
         for (int r = 0; r < 128; r++) if (($urandom % 4) == 0) fill_rand(r);
         run_tile($urandom_range(0, 127), $urandom_range(0, 4095), $urandom_range(1, 24),
                  $urandom_range(0, 31), 1'($urandom), t % 2, 0);
      end
      rdy_mode = 0;

      // Reset mid-tile aborts with no done pulse.
      prep(50, 'h600, 20, 0, 0, 0);
      kick(50, 'h600, 20, 0, 0);
      repeat (4) @(posedge clk_i);
      #1 rst_i = 0;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_wr", ub_write_o, 0);
      chk("abort_rd", acc_rd_en_o, 0);
      n0 = n_acc; r0 = n_rd;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1;
      repeat (30) @(posedge clk_i);
      #1;
      chk("abort_done", n_done, 0);
      chk("abort_nowr", n_acc, n0);
      chk("abort_nord", n_rd, r0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
